// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared geometry and scan-state encoding for the 5x7 LED matrix
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int N_COLS    = 5;
  localparam int N_ROWS    = 7;
  localparam int FRAME_W   = N_COLS * N_ROWS;
  localparam int COL_IDX_W = 3;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/matrix_scan_driver_scan_timer.sv
// ============================================================================
// scan_timer : phase counter with terminal-count flag against a supplied limit
// Revision   : 1.0
// ============================================================================
`default_nettype none

module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_d_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last_o = (cnt_q == limit_i);

  // Wrapping to zero on terminal count lets the caller switch phases without a separate load.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || last_o) begin
      cnt_d = '0;
    end
  end

  assign cnt_d_o = cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_scan_driver.sv
// ============================================================================
// matrix_scan_driver : column-multiplexed 5x7 LED driver with shadowed frames
// Revision           : 1.0
// ============================================================================
`default_nettype none

module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int DIV          = 4096,
  parameter int BLANK_CYCLES = 16,
  parameter int COL_ACT_LOW  = 1,
  parameter int ROW_ACT_LOW  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [N_COLS-1:0]  col,
  output logic [N_ROWS-1:0]  row,
  output logic               frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LIM   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(N_COLS - 1);
  localparam logic [N_COLS-1:0] COL_OFF = (COL_ACT_LOW != 0) ? '1 : '0;
  localparam logic [N_ROWS-1:0] ROW_OFF = (ROW_ACT_LOW != 0) ? '1 : '0;

  state_t               state_q, state_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic [FRAME_W-1:0]   active_q, active_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [N_COLS-1:0]    col_q, col_d, col_on;
  logic [N_ROWS-1:0]    row_q, row_d, row_on;
  logic                 done_q, done_d;

  logic [CW-1:0] tmr_limit;
  logic [CW-1:0] tmr_cnt_d;
  logic          tmr_last;
  logic          xfer;

  assign tmr_limit = (state_q == ST_BLANK) ? BLANK_LIM : DIV_LIM;
  assign xfer      = frame_valid && !pending_q;

  scan_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (!enable),
    .limit_i (tmr_limit),
    .cnt_d_o (tmr_cnt_d),
    .last_o  (tmr_last)
  );

  // A transfer can only land while pending is clear, so it never collides with a swap.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (xfer) begin
      shadow_d  = frame_data;
      pending_d = 1'b1;
    end
    if (!enable) begin
      state_d   = ST_BLANK;
      col_idx_d = '0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (tmr_last) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_DRIVE;
      end else begin
        state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        if (col_idx_q == LAST_COL) begin
          col_idx_d = '0;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          col_idx_d = col_idx_q + COL_IDX_W'(1);
        end
      end
    end
  end

  // Pin levels are computed from next state so the outputs are plain flops.
  always_comb begin
    col_on = '0;
    row_on = '0;
    if (state_d == ST_DRIVE) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (col_idx_d == COL_IDX_W'(c)) begin
          col_on[c] = 1'b1;
          row_on    = active_d[c*N_ROWS +: N_ROWS];
        end
      end
    end
    col_d  = col_on ^ COL_OFF;
    row_d  = row_on ^ ROW_OFF;
    done_d = (state_d == ST_DRIVE) && (col_idx_d == LAST_COL) && (tmr_cnt_d == DIV_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_BLANK;
      col_idx_q <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      col_q     <= COL_OFF;
      row_q     <= ROW_OFF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      col_q     <= col_d;
      row_q     <= row_d;
      done_q    <= done_d;
    end
  end

  assign frame_ready = !pending_q;
  assign col         = col_q;
  assign row         = row_q;
  assign frame_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
// ============================================================================
// tb_matrix_scan_driver : directed stimulus with a cycle-stamped scoreboard
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scan_driver;

  typedef struct {
    int         cyc;
    bit         is_rdy;
    logic [4:0] col;
    logic [6:0] row;
    logic       done;
    logic       rdy;
    string      nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [34:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [4:0]  col;
  logic [6:0]  row;
  logic        frame_done;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  localparam logic [34:0] FR_0  = 35'h0;
  localparam logic [34:0] FR_FA = (35'd1 << 0) | (35'd1 << 34);
  localparam logic [34:0] FR_A  = (35'd1 << 10) | (35'd1 << 20);
  localparam logic [34:0] FR_B  = 35'h7F | (35'd1 << 23);
  localparam logic [34:0] FR_C  = (35'd1 << 14) | (35'd1 << 6);
  localparam logic [34:0] FR_D  = (35'd1 << 22) | (35'd1 << 26) | (35'd1 << 18);
  localparam logic [34:0] FR_E  = '1;

  matrix_scan_driver #(
    .DIV          (4),
    .BLANK_CYCLES (1),
    .COL_ACT_LOW  (1),
    .ROW_ACT_LOW  (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .col         (col),
    .row         (row),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input exp_t e);
    int k = sb.size();
    while (k > 0 && sb[k-1].cyc > e.cyc) k--;
    sb.insert(k, e);
  endtask

  task automatic push_rdy(input string nm, input int c, input logic r);
    exp_t e;
    e.cyc = c; e.is_rdy = 1'b1; e.rdy = r; e.nm = nm;
    e.col = '0; e.row = '0; e.done = 1'b0;
    push(e);
  endtask

  task automatic push_idle(input string nm, input int c);
    exp_t e;
    e.cyc = c; e.is_rdy = 1'b0; e.rdy = 1'b0; e.nm = nm;
    e.col = 5'b11111; e.row = 7'b0; e.done = 1'b0;
    push(e);
  endtask

  // Hand-derived scan shape for DIV=4, BLANK=1: 4 drive cycles then 1 blank per column.
  task automatic push_scan(input string nm, input int start, input int len, input logic [34:0] frm);
    for (int i = 0; i < len; i++) begin
      exp_t       e;
      int         ph;
      int         c;
      logic [4:0] oh;
      ph = i % 25;
      c  = ph / 5;
      e.cyc = start + i; e.is_rdy = 1'b0; e.rdy = 1'b0; e.nm = nm;
      if ((ph % 5) < 4) begin
        oh    = 5'd1 << c;
        e.col = ~oh;
        e.row = frm[c*7 +: 7];
      end else begin
        e.col = 5'b11111;
        e.row = 7'b0;
      end
      e.done = (ph == 23);
      push(e);
    end
  endtask

  task automatic go(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cyc %0d missed, now cyc %0d", e.nm, e.cyc, cyc);
      end else if (e.is_rdy) begin
        if (frame_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: frame_ready=%b, expected %b", e.nm, cyc, frame_ready, e.rdy);
        end
      end else if (col !== e.col || row !== e.row || frame_done !== e.done) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: col=%b row=%b done=%b, expected col=%b row=%b done=%b",
                 e.nm, cyc, col, row, frame_done, e.col, e.row, e.done);
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_data = '0;

    // Reset, first load with swap while disabled, then free-running scan.
    push_idle("reset_out", 3); push_rdy("reset_rdy", 3, 1'b1);
    push_idle("idle_load", 4); push_rdy("rdy_after_xfer", 4, 1'b0);
    push_idle("idle_swap", 5); push_rdy("rdy_after_swap", 5, 1'b1);
    push_scan("scan_FA", 6, 75, FR_FA);
    go(3);   reset_n = 1'b1; frame_valid = 1'b1; frame_data = FR_FA;
    go(4);   frame_valid = 1'b0;
    go(5);   enable = 1'b1;

    // Backpressure: A accepted, B held until the boundary frees the shadow.
    push_rdy("bp_rdy_pre", 57, 1'b1);  push_rdy("bp_rdy_lowA", 59, 1'b0);
    push_rdy("bp_rdy_lowZ", 79, 1'b0); push_rdy("bp_rdy_free", 80, 1'b1);
    push_rdy("bp_rdy_lowB", 81, 1'b0); push_rdy("bp_rdy_B_end", 104, 1'b0);
    push_rdy("bp_rdy_freeB", 105, 1'b1);
    push_scan("scan_A", 81, 25, FR_A);
    push_scan("scan_B", 106, 50, FR_B);
    go(58);  frame_valid = 1'b1; frame_data = FR_A;
    go(59);  frame_data = FR_B;
    go(81);  frame_valid = 1'b0;

    // Transfer coinciding with the boundary waits a full frame.
    push_rdy("bnd_rdy_pre", 129, 1'b1); push_rdy("bnd_rdy_low", 130, 1'b0);
    push_rdy("bnd_rdy_held", 154, 1'b0); push_rdy("bnd_rdy_free", 155, 1'b1);
    push_scan("scan_C", 156, 12, FR_C);
    go(129); frame_valid = 1'b1; frame_data = FR_C;
    go(130); frame_valid = 1'b0;

    // Disable mid column 2 with D pending: immediate dark and swap.
    push_rdy("dis_rdy_pend", 159, 1'b0); push_rdy("dis_rdy_swap", 168, 1'b1);
    push_idle("dis_dark0", 168); push_idle("dis_dark1", 169);
    push_scan("scan_D", 170, 16, FR_D);
    go(158); frame_valid = 1'b1; frame_data = FR_D;
    go(159); frame_valid = 1'b0;
    go(167); enable = 1'b0;
    go(169); enable = 1'b1;

    // Reset during column 3 with E pending: E is dropped, display stays dark.
    push_rdy("rst_rdy_pend", 176, 1'b0);
    push_rdy("rst_rdy0", 186, 1'b1); push_rdy("rst_rdy1", 187, 1'b1);
    push_idle("rst_dark0", 186); push_idle("rst_dark1", 187);
    push_rdy("rst_rdy_late", 217, 1'b1);
    push_scan("scan_dark", 188, 30, FR_0);
    go(175); frame_valid = 1'b1; frame_data = FR_E;
    go(176); frame_valid = 1'b0;
    go(185); reset_n = 1'b0; enable = 1'b0;
    go(187); reset_n = 1'b1; enable = 1'b1;

    go(220);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: check for cyc %0d never reached", e.nm, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
